zr_icb_ram: RTL
===============

# zr_icb_ram

ICB responder that terminates a 32-bit ICB initiator port, such as the coreplex data port, on a single-port synchronous word RAM. It accepts one command per cycle, performs byte-masked writes and 1-cycle-latency reads, and returns responses in order through a 2-entry response buffer, so back-pressure on the response channel never drops data. It sits beside the peripheral subsystem on the SoC data bus as general-purpose scratch memory.

## Interface
Parameters:
- ADDR_BASE, 32'h9000_0000, byte base address of the RAM window
- AWIDTH, 12, number of byte-address LSBs decoded; RAM holds 2^(AWIDTH-2) words of 32 bits; legal range 3..20

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted when valid && ready
- icb_cmd_read  in  1  1 = read, 0 = write
- icb_cmd_addr  in  32  byte address; bits [1:0] ignored
- icb_cmd_wdata  in  32  write data
- icb_cmd_wmask  in  4  byte write enables, bit i ↔ wdata[8i+7:8i]
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response consumed when valid && ready
- icb_rsp_rdata  out  32  read data; 0 for writes and errors
- icb_rsp_err  out  1  access error

## Operation
- Word index = icb_cmd_addr[AWIDTH-1:2].
- Hit: icb_cmd_addr[31:AWIDTH] == ADDR_BASE[31:AWIDTH] (ADDR_BASE must be 2^AWIDTH aligned).
- Write hit: bytes with wmask=1 are written on the accept edge. Response is rdata=0, err=0. wmask=0 is a legal no-op write.
- Read hit: RAM is read on the accept edge. Data is registered into the response buffer on the next edge.
- Miss: behaviour set by the Configuration section. A miss never modifies the RAM.
- Responses return strictly in command order, one response per accepted command.
- Credit counter `reserved` = buffered responses + in-flight read (0..2).
  - icb_cmd_ready = (reserved < 2).
  - icb_cmd_ready is computed from registered state only. There is no combinational path from icb_rsp_ready or icb_cmd_valid to icb_cmd_ready.
- On the same edge as a push, an accept and a pop may all occur. The counter updates by +accept −pop and never exceeds 2 or underflows.
- icb_rsp_valid = buffer non-empty. Once asserted, rsp_valid, rdata and err hold stable until the response is popped.
- RAM contents are not reset. They are undefined until written.

## Timing
- Reset values: icb_rsp_valid=0, icb_rsp_rdata=0, icb_rsp_err=0, icb_cmd_ready=1 (reserved=0).
- Latency: a command accepted on edge N gives icb_rsp_valid=1 in the cycle after edge N, when the buffer was empty. This holds for reads, writes and errors.
- Throughput: with icb_rsp_ready held at 1, one command is accepted every cycle indefinitely.
- With icb_rsp_ready held at 0: two commands are accepted, then icb_cmd_ready=0 until a pop.
- Read-after-write to the same word on consecutive accepts returns the new data.
- Reset asserted mid-operation discards in-flight and buffered responses immediately, and outputs return to their reset values asynchronously.

## Configuration
- ZR_ICB_RAM_ERR_EN:
  - Defined: a miss returns err=1, rdata=0, with the same latency as a hit.
  - Undefined: address bits [31:AWIDTH] are ignored and the window aliases modulo 2^AWIDTH. err is tied to 0.

## Structure
- Shared package zr_icb_pkg:
  - ICB_DW=32 and ICB_MW=4.
  - typedef icb_rsp_t {rdata, err}, used as the buffer entry type.
  - typedef icb_cmd_t {read, addr, wdata, wmask}.
- One sub-module, zr_icb_rsp_buf: a 2-entry in-order FIFO of icb_rsp_t with push, pop, count and head outputs, async active-low reset.
- RAM is an inferred array in zr_icb_ram with a per-byte write enable.

## Test plan
- Write 0xDEADBEEF with mask 0xF to ADDR_BASE+0x10, then read ADDR_BASE+0x10 → rdata=0xDEADBEEF, err=0, rsp_valid one cycle after each accept.
- Write 0x11223344 with mask 0b0101 over an existing 0xAABBCCDD, then read the word → 0xAA22CC44.
- With rsp_ready=0, issue 4 back-to-back reads → exactly 2 accepted and cmd_ready=0. Raise rsp_ready → the remaining 2 are accepted and all 4 responses arrive in order with correct data.
- Streaming: 16 back-to-back writes then 16 reads with rsp_ready=1 → cmd_ready never drops and all data matches.
- Read ADDR_BASE+2^AWIDTH → with ZR_ICB_RAM_ERR_EN: err=1, rdata=0. Without it: rdata equals the word at ADDR_BASE, err=0.
- Assert rst_n low while 2 responses are buffered → rsp_valid=0 immediately. After release, cmd_ready=1 and no stale response appears.

Source files
------------

// File: rtl/zr_icb_pkg.sv
// Shared ICB definitions: bus widths, command/response records and the
// response-buffer depth used by zr_icb_ram and zr_icb_rsp_buf.
package zr_icb_pkg;

    localparam int ICB_AW    = 32;
    localparam int ICB_DW    = 32;
    localparam int ICB_MW    = 4;
    localparam int RSP_DEPTH = 2;

    typedef logic [1:0] credit_t;

    typedef struct packed {
        logic [ICB_DW-1:0] rdata;
        logic              err;
    } icb_rsp_t;

    typedef struct packed {
        logic              read;
        logic [ICB_AW-1:0] addr;
        logic [ICB_DW-1:0] wdata;
        logic [ICB_MW-1:0] wmask;
    } icb_cmd_t;

endpackage

// File: rtl/zr_icb_rsp_buf.sv
// Two-entry in-order response FIFO. The caller guarantees it never pushes
// into a full buffer or pops an empty one.
module zr_icb_rsp_buf
    import zr_icb_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push_i,
    input  icb_rsp_t push_data_i,
    input  logic     pop_i,
    output credit_t  count_o,
    output icb_rsp_t head_o
);

    icb_rsp_t entry_q [RSP_DEPTH];
    icb_rsp_t entry_d [RSP_DEPTH];
    logic     wr_ptr_q, wr_ptr_d;
    logic     rd_ptr_q, rd_ptr_d;
    credit_t  count_q,  count_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        entry_d  = entry_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            entry_d[wr_ptr_q] = push_data_i;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is updated with <= only, so all flops see pre-edge values.
        if (!rst_n) begin
            entry_q  <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            entry_q  <= entry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/zr_icb_ram.sv
// ICB responder on a single-port byte-masked word RAM with in-order responses.
// Optional macro ZR_ICB_RAM_ERR_EN: out-of-window accesses return err=1.
module zr_icb_ram
    import zr_icb_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h9000_0000,
    parameter int          AWIDTH    = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icb_cmd_valid,
    output logic              icb_cmd_ready,
    input  logic              icb_cmd_read,
    input  logic [31:0]       icb_cmd_addr,
    input  logic [ICB_DW-1:0] icb_cmd_wdata,
    input  logic [ICB_MW-1:0] icb_cmd_wmask,
    output logic              icb_rsp_valid,
    input  logic              icb_rsp_ready,
    output logic [ICB_DW-1:0] icb_rsp_rdata,
    output logic              icb_rsp_err
);

    localparam int IW    = AWIDTH - 2;
    localparam int WORDS = 2 ** IW;

    icb_cmd_t          cmd;
    logic              cmd_hit;
    logic              cmd_accept;
    logic              ram_wr_en;
    logic              ram_rd_en;
    logic [IW-1:0]     word_idx;
    logic [ICB_DW-1:0] mem [WORDS];
    logic [ICB_DW-1:0] ram_dout_q;
    logic              unused_addr_bits;

    // Stage 1 holds every accepted command for one cycle; reads wait here for RAM data.
    logic     s1_valid_q, s1_valid_d;
    logic     s1_rd_q,    s1_rd_d;
    logic     s1_err_q,   s1_err_d;
    icb_rsp_t s1_rsp;

    credit_t  buf_count;
    icb_rsp_t buf_head;
    icb_rsp_t rsp_out;
    logic     buf_push;
    logic     buf_pop;
    logic     rsp_pop;
    credit_t  reserved;

    always_comb begin
        cmd.read  = icb_cmd_read;
        cmd.addr  = icb_cmd_addr;
        cmd.wdata = icb_cmd_wdata;
        cmd.wmask = icb_cmd_wmask;
    end

`ifdef ZR_ICB_RAM_ERR_EN
    assign cmd_hit          = (cmd.addr[31:AWIDTH] == ADDR_BASE[31:AWIDTH]);
    assign unused_addr_bits = ^cmd.addr[1:0];
`else
    assign cmd_hit          = 1'b1;
    assign unused_addr_bits = ^{cmd.addr[31:AWIDTH], cmd.addr[1:0]};
`endif

    assign word_idx   = cmd.addr[AWIDTH-1:2];
    assign reserved   = buf_count + {1'b0, s1_valid_q};
    assign icb_cmd_ready = (reserved != 2'd2);
    assign cmd_accept = icb_cmd_valid & icb_cmd_ready;
    assign ram_wr_en  = cmd_accept & ~cmd.read & cmd_hit;
    assign ram_rd_en  = cmd_accept &  cmd.read & cmd_hit;

    // NOTE: the RAM array and its read register are never reset, so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (ram_rd_en) begin
            ram_dout_q <= mem[word_idx];
        end
        if (ram_wr_en) begin
            for (int b = 0; b < ICB_MW; b++) begin
                if (cmd.wmask[b]) begin
                    mem[word_idx][8*b +: 8] <= cmd.wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        s1_valid_d = cmd_accept;
        s1_rd_d    = ram_rd_en;
        s1_err_d   = cmd_accept & ~cmd_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_rd_q    <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rd_q    <= s1_rd_d;
            s1_err_q   <= s1_err_d;
        end
    end

    always_comb begin
        s1_rsp.rdata = s1_rd_q ? ram_dout_q : '0;
        s1_rsp.err   = s1_err_q;
    end

    // When the FIFO is empty the stage-1 response is presented directly; if it is
    // not consumed it moves into the FIFO unchanged, so the outputs stay stable.
    always_comb begin
        rsp_out = '0;
        if (buf_count != 2'd0) begin
            rsp_out = buf_head;
        end else if (s1_valid_q) begin
            rsp_out = s1_rsp;
        end
    end

    assign icb_rsp_valid = (buf_count != 2'd0) | s1_valid_q;
    assign rsp_pop       = icb_rsp_valid & icb_rsp_ready;
    assign buf_pop       = rsp_pop & (buf_count != 2'd0);
    assign buf_push      = s1_valid_q & ~(rsp_pop & (buf_count == 2'd0));

    zr_icb_rsp_buf u_rsp_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (buf_push),
        .push_data_i (s1_rsp),
        .pop_i       (buf_pop),
        .count_o     (buf_count),
        .head_o      (buf_head)
    );

    assign icb_rsp_rdata = rsp_out.rdata;
    assign icb_rsp_err   = rsp_out.err;

endmodule
